// File: rtl/fft_iter_pkg.sv
// fft_iter_pkg: state encoding, pipeline depth, layer limits and bit reversal shared by the FFT scheduler
package fft_iter_pkg;
   typedef enum logic [2:0] {IDLE, RUN, DRAIN, UNLOAD, FINISH} state_t;
   localparam int LOG2N_MIN = 1;
   function automatic int pipe_depth(input int rd_lat, input int but_lat);
      return rd_lat + but_lat;
   endfunction
   function automatic logic log2n_ok(input int v, input int max_awl);
      return v >= LOG2N_MIN && v <= max_awl;
   endfunction
   function automatic logic [31:0] bitrev(input logic [31:0] x, input int l);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++)
         if (i < l) r[i] = x[5'(l - 1 - i)];
      return r;
   endfunction
endpackage

// File: rtl/fft_iter_sched_unit_if.sv
// fft_iter_sched_unit_if: control and address bundle of the FFT scheduler
// FFT_SCHED_BITREV_OUT_EN adds the natural-order readout signals
interface fft_iter_sched_unit_if #(
   parameter int MAX_AWL = 10,
   parameter int LayWL = 4
);
   logic EN, START, i_INVERSE;
   logic [LayWL-1:0] i_LOG2N, o_LAYER;
   logic o_BUSY, o_DONE, o_ERR, o_SRC_SEL, o_RD_EN, o_W_CONJ, o_WR_EN;
   logic [MAX_AWL-1:0] o_RD_A_ADDR, o_RD_B_ADDR, o_WR_A_ADDR, o_WR_B_ADDR;
   logic [MAX_AWL-2:0] o_W_ADDR;
`ifdef FFT_SCHED_BITREV_OUT_EN
   logic o_OUT_VALID;
   logic [MAX_AWL-1:0] o_OUT_ADDR;
`endif
   modport master (
      output EN, START, i_LOG2N, i_INVERSE,
      input o_BUSY, o_DONE, o_ERR, o_SRC_SEL, o_LAYER, o_RD_EN, o_RD_A_ADDR, o_RD_B_ADDR,
      input o_W_ADDR, o_W_CONJ, o_WR_EN, o_WR_A_ADDR, o_WR_B_ADDR
`ifdef FFT_SCHED_BITREV_OUT_EN
      , input o_OUT_VALID, o_OUT_ADDR
`endif
   );
   modport slave (
      input EN, START, i_LOG2N, i_INVERSE,
      output o_BUSY, o_DONE, o_ERR, o_SRC_SEL, o_LAYER, o_RD_EN, o_RD_A_ADDR, o_RD_B_ADDR,
      output o_W_ADDR, o_W_CONJ, o_WR_EN, o_WR_A_ADDR, o_WR_B_ADDR
`ifdef FFT_SCHED_BITREV_OUT_EN
      , output o_OUT_VALID, o_OUT_ADDR
`endif
   );
endinterface

// File: rtl/fft_addr_delay_line.sv
// fft_addr_delay_line: EN-gated valid-tagged shift register aligning write-back with butterfly results
module fft_addr_delay_line #(
   parameter int DEPTH = 4,
   parameter int AW = 10
) (
   input logic CLK,
   input logic RST,
   input logic EN,
   input logic i_V,
   input logic [AW-1:0] i_A,
   input logic [AW-1:0] i_B,
   output logic o_V,
   output logic [AW-1:0] o_A,
   output logic [AW-1:0] o_B
);
   logic [2*AW:0] sr [DEPTH];
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (EN) begin
         sr[0] <= {i_V, i_A, i_B};
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   assign {o_V, o_A, o_B} = sr[DEPTH-1];
endmodule

// File: rtl/fft_iter_sched_unit.sv
// fft_iter_sched_unit: in-place radix-2 DIF FFT scheduler (addresses, twiddles, strobes, busy/done)
// FFT_SCHED_BITREV_OUT_EN adds an UNLOAD phase emitting bit-reversed readout addresses
module fft_iter_sched_unit
   import fft_iter_pkg::*;
#(
   parameter int MAX_AWL = 10,
   parameter int LayWL = 4,
   parameter int BUT_LAT = 3,
   parameter int RD_LAT = 1
) (
   input logic CLK,
   input logic RST,
   fft_iter_sched_unit_if.slave bus
);
   localparam int PIPE = pipe_depth(RD_LAT, BUT_LAT);
   localparam int CW = (MAX_AWL > $clog2(PIPE)) ? MAX_AWL : $clog2(PIPE);
   localparam int WW = MAX_AWL - 1;
`ifdef FFT_SCHED_BITREV_OUT_EN
   localparam state_t POST = UNLOAD;
`else
   localparam state_t POST = FINISH;
`endif
   state_t state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [LayWL-1:0] layer, layer_n, len;
   logic inv, accept, err, run, last, wv;
   logic [MAX_AWL-1:0] k, nm1, hm, a, b;
   logic [WW-1:0] w;

   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state <= IDLE;
         cnt <= '0;
         layer <= '0;
         len <= '0;
         inv <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         layer <= layer_n;
         if (accept) begin
            len <= bus.i_LOG2N;
            inv <= bus.i_INVERSE;
         end
      end

   // hm = H-1 masks the in-group offset; the bits above it select the group
   assign k = cnt[MAX_AWL-1:0];
   assign nm1 = {MAX_AWL{1'b1}} >> (MAX_AWL - int'(len));
   assign hm = nm1 >> (int'(layer) + 1);
   assign a = ((k & ~hm) << 1) | (k & hm);
   assign b = a | (hm + 1'b1);
   assign w = WW'((k & hm) << (int'(layer) + MAX_AWL - int'(len)));
   assign last = layer == len - 1'b1;

   always_comb begin
      state_n = state;
      cnt_n = cnt;
      layer_n = layer;
      accept = 1'b0;
      err = 1'b0;
      if (bus.EN)
         case (state)
            IDLE: if (bus.START) begin
               accept = log2n_ok(int'(bus.i_LOG2N), MAX_AWL);
               err = !accept;
               if (accept) begin
                  state_n = RUN;
                  cnt_n = '0;
                  layer_n = '0;
               end
            end
            RUN: begin
               cnt_n = (k == (nm1 >> 1)) ? '0 : cnt + 1'b1;
               state_n = (k == (nm1 >> 1)) ? DRAIN : RUN;
            end
            DRAIN: if (cnt == CW'(PIPE - 1)) begin
               cnt_n = '0;
               layer_n = last ? layer : layer + 1'b1;
               state_n = last ? POST : RUN;
            end else cnt_n = cnt + 1'b1;
            UNLOAD: begin
               cnt_n = (k == nm1) ? '0 : cnt + 1'b1;
               state_n = (k == nm1) ? FINISH : UNLOAD;
            end
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
         endcase
   end

   assign run = state == RUN;
   assign bus.o_RD_EN = run && bus.EN;
   assign bus.o_SRC_SEL = run && layer == '0;
   assign bus.o_LAYER = layer;
   assign bus.o_RD_A_ADDR = run ? a : '0;
   assign bus.o_RD_B_ADDR = run ? b : '0;
   assign bus.o_W_ADDR = run ? w : '0;
   assign bus.o_W_CONJ = inv;
   assign bus.o_BUSY = accept || state inside {RUN, DRAIN, UNLOAD};
   assign bus.o_DONE = bus.EN && state == FINISH;
   assign bus.o_ERR = err;
   assign bus.o_WR_EN = wv && bus.EN;
`ifdef FFT_SCHED_BITREV_OUT_EN
   assign bus.o_OUT_VALID = bus.EN && state == UNLOAD;
   assign bus.o_OUT_ADDR = state == UNLOAD ? MAX_AWL'(bitrev(32'(k), int'(len))) : '0;
`endif

   fft_addr_delay_line #(.DEPTH(PIPE), .AW(MAX_AWL)) u_dly (
      .CLK(CLK),
      .RST(RST),
      .EN(bus.EN),
      .i_V(bus.o_RD_EN),
      .i_A(bus.o_RD_A_ADDR),
      .i_B(bus.o_RD_B_ADDR),
      .o_V(wv),
      .o_A(bus.o_WR_A_ADDR),
      .o_B(bus.o_WR_B_ADDR)
   );
endmodule

// File: tb/tb_fft_iter_sched_unit.sv
// tb_fft_iter_sched_unit: directed and randomized check of the FFT scheduler against a loop-nest model
module tb_fft_iter_sched_unit;
   localparam int AW = 4;
   localparam int LW = 4;
   localparam int PIPE = 4;
   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   fft_iter_sched_unit_if #(.MAX_AWL(AW), .LayWL(LW)) bus ();
   fft_iter_sched_unit #(.MAX_AWL(AW), .LayWL(LW), .BUT_LAT(3), .RD_LAT(1)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   typedef struct {int layer; int a; int b; int w; int src; int conj; int cyc;} rd_t;
   typedef struct {int a; int b; int cyc;} wr_t;
   rd_t rq[$];
   rd_t eq[$];
   wr_t wq[$];
   int oq[$];
   int ocyc[$];
   int cyc = 0, busy_n, first_busy, done_cyc, done_n, err_n;
   int tests = 0, fails = 0;
   logic prev_busy = 1'b0;

   always @(negedge CLK) begin
      cyc = cyc + 1;
      if (bus.o_RD_EN)
         rq.push_back('{int'(bus.o_LAYER), int'(bus.o_RD_A_ADDR), int'(bus.o_RD_B_ADDR),
                        int'(bus.o_W_ADDR), int'(bus.o_SRC_SEL), int'(bus.o_W_CONJ), cyc});
      if (bus.o_WR_EN) wq.push_back('{int'(bus.o_WR_A_ADDR), int'(bus.o_WR_B_ADDR), cyc});
      if (bus.o_BUSY) busy_n++;
      if (bus.o_BUSY && !prev_busy) first_busy = cyc;
      prev_busy = bus.o_BUSY;
      if (bus.o_DONE) begin
         done_n++;
         done_cyc = cyc;
      end
      if (bus.o_ERR) err_n++;
`ifdef FFT_SCHED_BITREV_OUT_EN
      if (bus.o_OUT_VALID) begin
         oq.push_back(int'(bus.o_OUT_ADDR));
         ocyc.push_back(cyc);
      end
`endif
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [63:0] key(input rd_t r);
      return 64'({8'(r.layer), 8'(r.src), 8'(r.conj), 8'(r.a), 8'(r.b), 8'(r.w)});
   endfunction

   function automatic int rev(input int x, input int l);
      int r = 0;
      for (int i = 0; i < l; i++) r = r * 2 + ((x >> i) & 1);
      return r;
   endfunction

   function automatic logic [63:0] outs();
      return 64'({bus.o_BUSY, bus.o_DONE, bus.o_ERR, bus.o_SRC_SEL, bus.o_LAYER, bus.o_RD_EN,
                  bus.o_RD_A_ADDR, bus.o_RD_B_ADDR, bus.o_W_ADDR, bus.o_W_CONJ, bus.o_WR_EN,
                  bus.o_WR_A_ADDR, bus.o_WR_B_ADDR
`ifdef FFT_SCHED_BITREV_OUT_EN
                  , bus.o_OUT_VALID, bus.o_OUT_ADDR
`endif
                  });
   endfunction

   task automatic clear();
      rq.delete();
      wq.delete();
      oq.delete();
      ocyc.delete();
      busy_n = 0;
      done_n = 0;
      err_n = 0;
      first_busy = -1;
      done_cyc = -1;
   endtask

   // every butterfly of every layer in group-major order
   task automatic build(input int l, input int inv);
      int n = 1 << l;
      eq.delete();
      for (int ly = 0; ly < l; ly++) begin
         int g = n >> ly;
         int h = g / 2;
         for (int base = 0; base < n; base += g)
            for (int j = 0; j < h; j++)
               eq.push_back('{ly, base + j, base + j + h, j * (1 << ly) * (1 << (AW - l)),
                              int'(ly == 0), inv, 0});
      end
   endtask

   task automatic run(input int l, input int inv, input int gap_at, input int gap_len,
                      input int bad_at, input int bad_lg);
      int n, exp_busy, t, gapped, half;
      n = 1 << l;
      half = n / 2;
      exp_busy = l * (half + PIPE) + 1 + gap_len;
`ifdef FFT_SCHED_BITREV_OUT_EN
      exp_busy += n;
`endif
      build(l, inv);
      clear();
      bus.START = 1'b1;
      bus.i_LOG2N = LW'(l);
      bus.i_INVERSE = inv[0];
      tick();
      bus.START = 1'b0;
      t = 0;
      gapped = 0;
      while (done_n == 0 && t < 2000) begin
         if (!gapped && gap_len > 0 && rq.size() == gap_at) begin
            gapped = 1;
            bus.EN = 1'b0;
            repeat (gap_len) tick();
            bus.EN = 1'b1;
         end
         bus.START = t == bad_at;
         bus.i_LOG2N = LW'(t == bad_at ? bad_lg : l);
         tick();
         t++;
      end
      bus.START = 1'b0;
      repeat (3) tick();
      chk($sformatf("L%0d.done_pulses", l), done_n, 1);
      chk($sformatf("L%0d.busy_cycles", l), busy_n, exp_busy);
      chk($sformatf("L%0d.done_latency", l), done_cyc - first_busy, exp_busy);
      chk($sformatf("L%0d.err_while_busy", l), err_n, 0);
      chk($sformatf("L%0d.rd_count", l), rq.size(), eq.size());
      chk($sformatf("L%0d.wr_count", l), wq.size(), eq.size());
      if (rq.size() > 0) chk($sformatf("L%0d.first_rd", l), rq[0].cyc - first_busy, 1);
      for (int i = 0; i < eq.size() && i < rq.size(); i++)
         chk($sformatf("L%0d.rd%0d", l, i), key(rq[i]), key(eq[i]));
      for (int i = 0; i < eq.size() && i < wq.size(); i++) begin
         chk($sformatf("L%0d.wr%0d", l, i), wq[i].a * 64 + wq[i].b, eq[i].a * 64 + eq[i].b);
         if (gap_len == 0 && i < rq.size())
            chk($sformatf("L%0d.wr%0d_lat", l, i), wq[i].cyc - rq[i].cyc, PIPE);
      end
      for (int ly = 1; ly < l; ly++)
         if (ly * half < rq.size() && ly * half - 1 < wq.size())
            chk($sformatf("L%0d.raw_layer%0d", l, ly),
                int'(rq[ly * half].cyc > wq[ly * half - 1].cyc), 1);
`ifdef FFT_SCHED_BITREV_OUT_EN
      chk($sformatf("L%0d.out_count", l), oq.size(), n);
      for (int i = 0; i < n && i < oq.size(); i++)
         chk($sformatf("L%0d.out%0d", l, i), oq[i], rev(i, l));
      if (oq.size() > 0 && wq.size() > 0)
         chk($sformatf("L%0d.out_after_wr", l), int'(ocyc[0] > wq[wq.size() - 1].cyc), 1);
`endif
   endtask

   task automatic bad(input int lg);
      clear();
      bus.START = 1'b1;
      bus.i_LOG2N = LW'(lg);
      tick();
      bus.START = 1'b0;
      repeat (3) tick();
      chk($sformatf("bad%0d.err_pulse", lg), err_n, 1);
      chk($sformatf("bad%0d.busy", lg), busy_n, 0);
      chk($sformatf("bad%0d.reads", lg), rq.size(), 0);
   endtask

   initial begin
      int t;
      bus.EN = 1'b1;
      bus.START = 1'b0;
      bus.i_LOG2N = '0;
      bus.i_INVERSE = 1'b0;
      repeat (2) tick();
      chk("reset_outs", outs(), 64'd0);
      RST = 1'b0;
      tick();
      chk("idle_outs", outs(), 64'd0);
      run(3, 0, 0, 0, -1, 0);
      bad(0);
      bad(AW + 1);
      run(1, 0, 0, 0, -1, 0);
      run(3, 1, 6, 3, 2, 0);
      clear();
      bus.START = 1'b1;
      bus.i_LOG2N = LW'(3);
      bus.i_INVERSE = 1'b1;
      tick();
      bus.START = 1'b0;
      t = 0;
      while (rq.size() < 4 && t < 100) begin
         tick();
         t++;
      end
      chk("rst_reached_drain", rq.size(), 4);
      RST = 1'b1;
      #1;
      chk("rst_outs_immediate", outs(), 64'd0);
      tick();
      RST = 1'b0;
      repeat (12) tick();
      chk("rst_no_wr", wq.size(), 0);
      chk("rst_idle_outs", outs(), 64'd0);
      run(3, 0, 0, 0, -1, 0);
      repeat (6) begin
         int l, total;
         l = $urandom_range(1, AW);
         total = l * (1 << l) / 2;
         run(l, $urandom_range(0, 1), $urandom_range(0, total - 1), $urandom_range(0, 3), 1,
             $urandom_range(0, 1) ? $urandom_range(AW + 1, 15) : $urandom_range(1, AW));
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
